tx_link_ctrl: RTL
=================

TX_LINK_CTRL -- requirements
Module: tx_link_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low (ports CLK, RST_n).
REQ-002 The block SHALL provide these ports:
- CLK  in  1  clock; one 4-octet beat per cycle
- RST_n  in  1  synchronous active-low reset
- F_ENC  in  8  octets per frame minus 1
- K_ENC  in  5  frames per multiframe minus 1
- SYNC_n  in  1  receiver sync request, active low
- SYSREF  in  1  LMFC alignment reference; rising edge significant
- MODE  out  2  00 CGS (K28.5 fill), 01 ILAS, 10 DATA, 11 unused
- ILAS_MF  out  2  ILAS multiframe index 0..3
- MF_START  out  1  first beat of a multiframe
- MF_END  out  1  last beat of a multiframe
- RDY  out  1  data phase active
- LMFC_VALID  out  1  at least one SYSREF edge seen
- SYNC_ERR  out  1  one-cycle pulse on sync loss after CGS
- SYSREF_ERR  out  1  one-cycle pulse on mis-phased SYSREF
- CFG_ERR  out  1  latched F/K invalid

Function
REQ-003 The block SHALL capture F_ENC/K_ENC into registers every cycle in state CGS and hold them in all other states.
REQ-004 F=F_ENC+1, K=K_ENC+1, P=(F*K)/4 (11 bits), all computed from the captured values.
REQ-005 CFG_ERR SHALL be 1 when (F*K) mod 4 != 0; while CFG_ERR=1 the FSM SHALL stay in CGS.
REQ-006 SYSREF SHALL be registered; edge = SYSREF & ~SYSREF_q.
REQ-007 LMFC counter: increments by 1 per cycle and wraps from P-1 to 0.
REQ-008 MF_START = (cnt==0); MF_END = (cnt==P-1); both 1 every cycle when P=1.
REQ-009 Edge in CGS or WAIT SHALL load cnt=0 next cycle and set LMFC_VALID (sticky until reset).
REQ-010 Edge in ILAS or DATA SHALL NOT modify cnt.
REQ-011 Edge in ILAS or DATA with cnt!=P-1 SHALL pulse SYSREF_ERR for 1 cycle; with cnt==P-1 no pulse.
REQ-012 FSM states SHALL be CGS, WAIT, ILAS, DATA; all transitions register at the clock edge.
REQ-013 CGS->WAIT SHALL occur when SYNC_n=1 AND LMFC_VALID=1 AND CFG_ERR=0 are sampled in one cycle.
REQ-014 WAIT->ILAS SHALL occur on a cycle with cnt==P-1, so that ILAS begins at cnt=0 with ILAS_MF=0.
REQ-015 In ILAS, ILAS_MF SHALL increment on each cycle with cnt==P-1; ILAS->DATA SHALL occur when ILAS_MF==3 and cnt==P-1, so ILAS lasts exactly 4*P cycles.
REQ-016 Sync loss SHALL be SYNC_n=0 sampled on 2 consecutive cycles; a single low cycle SHALL be ignored.
REQ-017 Sync loss in WAIT, ILAS or DATA SHALL go to CGS on the next cycle; SYNC_ERR SHALL pulse only from ILAS or DATA.
REQ-018 Sync loss SHALL take priority over any LMFC-boundary transition in the same cycle.
REQ-019 MODE SHALL be 00 in CGS and WAIT, 01 in ILAS, 10 in DATA.
REQ-020 RDY SHALL be (state==DATA).
REQ-021 ILAS_MF SHALL be 0 outside ILAS.
REQ-022 All outputs SHALL be registered or decoded directly from registers, with no combinational path from inputs.

Reset
REQ-023 When RST_n=0 is sampled, the next cycle SHALL show: state CGS, MODE=00, cnt=0, ILAS_MF=0, RDY=0, LMFC_VALID=0, SYNC_ERR=0, SYSREF_ERR=0, SYNC_n debounce cleared, captured F/K=0 (CFG_ERR=0 since F=K=1 gives 1 mod 4 -> CFG_ERR=1 the following cycle), SYSREF_q=0.
REQ-024 Reset asserted mid-ILAS or mid-DATA SHALL override all other events.

Verification
REQ-025 Reset, SYNC_n=1, no SYSREF for 100 cycles, F_ENC=3, K_ENC=7 -> MODE=00, LMFC_VALID=0, RDY=0 throughout.
REQ-026 F_ENC=3, K_ENC=7 (P=8), SYSREF pulse, then SYNC_n=1 -> WAIT until cnt=7, then ILAS for 32 cycles with ILAS_MF 0,1,2,3 (8 cycles each) and MF_START/MF_END at cnt 0/7, then MODE=10 and RDY=1 at cnt=0.
REQ-027 In DATA: SYNC_n low for 1 cycle -> no change; low for 2 cycles -> SYNC_ERR pulse, MODE=00, RDY=0 the next cycle; SYNC_n high again -> re-ILAS at the next boundary.
REQ-028 In DATA with P=8: SYSREF edge at cnt=3 -> SYSREF_ERR pulse and cnt continues 4,5,...; edge at cnt=7 -> no pulse.
REQ-029 F_ENC=2, K_ENC=1 (6 octets) with SYSREF and SYNC_n=1 -> CFG_ERR=1, MODE=00 indefinitely; F_ENC=1, K_ENC=1 (P=1) -> CFG_ERR=0, MF_START=MF_END=1 every cycle, ILAS lasts 4 cycles.
REQ-030 RST_n=0 for 1 cycle during ILAS_MF=2 -> all outputs at REQ-023 values the next cycle, and no SYNC_ERR pulse.

Source files
------------

// File: rtl/tx_link_ctrl_if.sv
// Link-layer control bundle for the JESD-style transmit controller.
// master drives config/sync/sysref; slave (the controller) drives status.
interface tx_link_ctrl_if;
  logic [7:0] F_ENC;
  logic [4:0] K_ENC;
  logic       SYNC_n;
  logic       SYSREF;
  logic [1:0] MODE;
  logic [1:0] ILAS_MF;
  logic       MF_START;
  logic       MF_END;
  logic       RDY;
  logic       LMFC_VALID;
  logic       SYNC_ERR;
  logic       SYSREF_ERR;
  logic       CFG_ERR;

  modport master (
    output F_ENC, K_ENC, SYNC_n, SYSREF,
    input  MODE, ILAS_MF, MF_START, MF_END, RDY,
    input  LMFC_VALID, SYNC_ERR, SYSREF_ERR, CFG_ERR
  );

  modport slave (
    input  F_ENC, K_ENC, SYNC_n, SYSREF,
    output MODE, ILAS_MF, MF_START, MF_END, RDY,
    output LMFC_VALID, SYNC_ERR, SYSREF_ERR, CFG_ERR
  );
endinterface

// File: rtl/tx_link_ctrl.sv
// Transmit link controller: LMFC counter, SYSREF alignment and
// CGS -> WAIT -> ILAS -> DATA sequencing with debounced SYNC_n.
module tx_link_ctrl (
  input  logic         CLK,
  input  logic         RST_n,
  tx_link_ctrl_if.slave lnk
);

  typedef enum logic [1:0] {
    S_CGS  = 2'd0,
    S_WAIT = 2'd1,
    S_ILAS = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  f_q, f_d;
  logic [4:0]  k_q, k_d;
  logic [10:0] cnt_q, cnt_d;
  logic [1:0]  ilas_mf_q, ilas_mf_d;
  logic        lv_q, lv_d;
  logic        sync_err_q, sync_err_d;
  logic        sysref_err_q, sysref_err_d;
  logic        cfg_err_q, cfg_err_d;
  logic        sysref_q, sysref_d;
  logic        sync_lo_q, sync_lo_d;

  logic [8:0]  f_val;
  logic [5:0]  k_val;
  logic [13:0] fk;
  logic [10:0] p;
  logic [10:0] p_m1;
  logic        last;
  logic        sr_edge;
  logic        loss;

  // Frame geometry from the captured configuration.
  assign f_val = {1'b0, f_q} + 9'd1;
  assign k_val = {1'b0, k_q} + 6'd1;
  assign fk    = {5'd0, f_val} * {8'd0, k_val};
  assign p     = fk[12:2];
  assign p_m1  = p - 11'd1;
  assign last  = (cnt_q == p_m1);

  assign sr_edge = lnk.SYSREF & ~sysref_q;
  assign loss    = ~lnk.SYNC_n & sync_lo_q;

  // Next-state logic for counter, FSM and status pulses.
  always_comb begin
    state_d      = state_q;
    f_d          = f_q;
    k_d          = k_q;
    ilas_mf_d    = ilas_mf_q;
    lv_d         = lv_q;
    sync_err_d   = 1'b0;
    sysref_err_d = 1'b0;
    sysref_d     = lnk.SYSREF;
    sync_lo_d    = ~lnk.SYNC_n;
    // F*K = 8192 would give a P that does not fit 11 bits: reject it.
    cfg_err_d    = (fk[1:0] != 2'b00) | fk[13];
    cnt_d        = (cnt_q >= p_m1) ? 11'd0 : cnt_q + 11'd1;

    unique case (state_q)
      S_CGS: begin
        f_d = lnk.F_ENC;
        k_d = lnk.K_ENC;
        if (sr_edge) begin
          cnt_d = 11'd0;
          lv_d  = 1'b1;
        end
        if (lnk.SYNC_n && lv_q && !cfg_err_q)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sr_edge) begin
          cnt_d = 11'd0;
          lv_d  = 1'b1;
        end
        if (loss) begin
          state_d = S_CGS;
        end else if (last) begin
          state_d   = S_ILAS;
          ilas_mf_d = 2'd0;
        end
      end
      S_ILAS: begin
        sysref_err_d = sr_edge & ~last;
        if (loss) begin
          state_d    = S_CGS;
          sync_err_d = 1'b1;
          ilas_mf_d  = 2'd0;
        end else if (last) begin
          if (ilas_mf_q == 2'd3) begin
            state_d   = S_DATA;
            ilas_mf_d = 2'd0;
          end else begin
            ilas_mf_d = ilas_mf_q + 2'd1;
          end
        end
      end
      S_DATA: begin
        sysref_err_d = sr_edge & ~last;
        if (loss) begin
          state_d    = S_CGS;
          sync_err_d = 1'b1;
        end
      end
      default: state_d = S_CGS;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q      <= S_CGS;
      f_q          <= 8'd0;
      k_q          <= 5'd0;
      cnt_q        <= 11'd0;
      ilas_mf_q    <= 2'd0;
      lv_q         <= 1'b0;
      sync_err_q   <= 1'b0;
      sysref_err_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      sysref_q     <= 1'b0;
      sync_lo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      f_q          <= f_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      ilas_mf_q    <= ilas_mf_d;
      lv_q         <= lv_d;
      sync_err_q   <= sync_err_d;
      sysref_err_q <= sysref_err_d;
      cfg_err_q    <= cfg_err_d;
      sysref_q     <= sysref_d;
      sync_lo_q    <= sync_lo_d;
    end
  end

  assign lnk.MODE       = (state_q == S_ILAS) ? 2'b01 :
                          (state_q == S_DATA) ? 2'b10 : 2'b00;
  assign lnk.ILAS_MF    = ilas_mf_q;
  assign lnk.MF_START   = (cnt_q == 11'd0);
  assign lnk.MF_END     = last;
  assign lnk.RDY        = (state_q == S_DATA);
  assign lnk.LMFC_VALID = lv_q;
  assign lnk.SYNC_ERR   = sync_err_q;
  assign lnk.SYSREF_ERR = sysref_err_q;
  assign lnk.CFG_ERR    = cfg_err_q;

endmodule
